// File: rtl/pre_interleaver_pkg.sv
// rtl/pre_interleaver_pkg.sv - shared constants and width helper for the pre-interleaver
package pre_interleaver_pkg;

    localparam logic MODE_INTERLEAVE   = 1'b0;
    localparam logic MODE_DEINTERLEAVE = 1'b1;

    // Counter width for a range of n values, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pre_interleaver_addr_gen.sv
// rtl/pre_interleaver_addr_gen.sv - row/column counter pair giving linear or transposed block addresses
module pre_interleaver_addr_gen
    import pre_interleaver_pkg::*;
#(
    parameter int CODEWORD_LEN  = 65,
    parameter int NUM_CODEWORDS = 4,
    localparam int BLOCK_SIZE   = CODEWORD_LEN * NUM_CODEWORDS,
    localparam int AW           = cnt_width(BLOCK_SIZE)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          adv,
    input  logic          transpose,
    output logic [AW-1:0] addr,
    output logic          last
);

    localparam int CWW = cnt_width(NUM_CODEWORDS);
    localparam int PW  = cnt_width(CODEWORD_LEN);

    // lin_q is the sequence index j; cw_q = j mod N, pos_q = j / N, base_q = cw_q * L
    logic [AW-1:0]  lin_q, lin_d;
    logic [CWW-1:0] cw_q, cw_d;
    logic [PW-1:0]  pos_q, pos_d;
    logic [AW-1:0]  base_q, base_d;

    assign last = (lin_q == AW'(BLOCK_SIZE - 1));
    assign addr = transpose ? (base_q + AW'(pos_q)) : lin_q;

    // Step both orderings together; transposed order walks codewords first, then word position
    always_comb begin
        lin_d  = lin_q;
        cw_d   = cw_q;
        pos_d  = pos_q;
        base_d = base_q;
        if (clr) begin
            lin_d  = '0;
            cw_d   = '0;
            pos_d  = '0;
            base_d = '0;
        end else if (adv) begin
            lin_d = last ? '0 : lin_q + AW'(1);
            if (cw_q == CWW'(NUM_CODEWORDS - 1)) begin
                cw_d   = '0;
                base_d = '0;
                pos_d  = (pos_q == PW'(CODEWORD_LEN - 1)) ? '0 : pos_q + PW'(1);
            end else begin
                cw_d   = cw_q + CWW'(1);
                base_d = base_q + AW'(CODEWORD_LEN);
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lin_q  <= '0;
            cw_q   <= '0;
            pos_q  <= '0;
            base_q <= '0;
        end else begin
            lin_q  <= lin_d;
            cw_q   <= cw_d;
            pos_q  <= pos_d;
            base_q <= base_d;
        end
    end

endmodule

// File: rtl/pre_interleaver_v2.sv
// rtl/pre_interleaver_v2.sv - ping-pong block interleaver/deinterleaver, optional err_cnt via PRE_INTERLEAVER_ERR_CNT_EN
module pre_interleaver_v2
    import pre_interleaver_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int CODEWORD_LEN  = 65,
    parameter int NUM_CODEWORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mode,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  err_tlast,
    input  logic                  err_clr
`ifdef PRE_INTERLEAVER_ERR_CNT_EN
    ,
    output logic [15:0]           err_cnt
`endif
);

    localparam int BLOCK_SIZE = CODEWORD_LEN * NUM_CODEWORDS;
    localparam int AW         = cnt_width(BLOCK_SIZE);
    localparam int MW         = cnt_width(2 * BLOCK_SIZE);

    logic [DATA_WIDTH-1:0] mem [0:2*BLOCK_SIZE-1];
    logic [DATA_WIDTH-1:0] rd_data_q;

    logic                  run_q, run_d;
    logic                  wr_bank_q, wr_bank_d;
    logic                  rd_bank_q, rd_bank_d;
    logic [1:0]            full_q, full_d;
    logic [1:0]            bank_mode_q, bank_mode_d;
    logic                  err_q, err_d;
    logic                  rd_vld_q, rd_vld_d;
    logic                  rd_last_q, rd_last_d;
    logic                  s0_vld_q, s0_vld_d, s1_vld_q, s1_vld_d;
    logic                  s0_last_q, s0_last_d, s1_last_q, s1_last_d;
    logic [DATA_WIDTH-1:0] s0_data_q, s0_data_d, s1_data_q, s1_data_d;

    logic          accept, issue, pop, err_set;
    logic [AW-1:0] wr_addr, rd_addr;
    logic          wr_last, rd_last;
    logic [MW-1:0] wr_mem_addr, rd_mem_addr;
    logic [1:0]    occ;

    // run_q keeps s_axis_tready low while in reset
    assign s_axis_tready = run_q && !full_q[wr_bank_q];
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign pop           = s0_vld_q && m_axis_tready;
    assign occ           = {1'b0, s0_vld_q} + {1'b0, s1_vld_q} + {1'b0, rd_vld_q};
    assign issue         = full_q[rd_bank_q] && ((occ < 2'd2) || ((occ == 2'd2) && pop));
    assign err_set       = accept && (s_axis_tlast != wr_last);

    assign wr_mem_addr = wr_bank_q ? (MW'(BLOCK_SIZE) + MW'(wr_addr)) : MW'(wr_addr);
    assign rd_mem_addr = rd_bank_q ? (MW'(BLOCK_SIZE) + MW'(rd_addr)) : MW'(rd_addr);

    assign m_axis_tvalid = s0_vld_q;
    assign m_axis_tdata  = s0_data_q;
    assign m_axis_tlast  = s0_vld_q && s0_last_q;
    assign err_tlast     = err_q;

    // Deinterleave writes transposed; the mode bit for a bank is latched on its first word
    pre_interleaver_addr_gen #(
        .CODEWORD_LEN (CODEWORD_LEN),
        .NUM_CODEWORDS(NUM_CODEWORDS)
    ) u_wr_addr (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (1'b0),
        .adv      (accept),
        .transpose(bank_mode_q[wr_bank_q] == MODE_DEINTERLEAVE),
        .addr     (wr_addr),
        .last     (wr_last)
    );

    // Interleave reads transposed, deinterleave reads linearly
    pre_interleaver_addr_gen #(
        .CODEWORD_LEN (CODEWORD_LEN),
        .NUM_CODEWORDS(NUM_CODEWORDS)
    ) u_rd_addr (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (1'b0),
        .adv      (issue),
        .transpose(bank_mode_q[rd_bank_q] == MODE_INTERLEAVE),
        .addr     (rd_addr),
        .last     (rd_last)
    );

    // Bank RAM: write port plus registered read, no reset so it maps to block RAM
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_mem_addr] <= s_axis_tdata;
        end
        if (issue) begin
            rd_data_q <= mem[rd_mem_addr];
        end
    end

    // Bank flags, error flag, read pipeline and two-entry output skid buffer
    always_comb begin
        run_d       = 1'b1;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        full_d      = full_q;
        bank_mode_d = bank_mode_q;
        err_d       = err_q;
        rd_vld_d    = issue;
        rd_last_d   = issue && rd_last;
        s0_vld_d    = s0_vld_q;
        s0_data_d   = s0_data_q;
        s0_last_d   = s0_last_q;
        s1_vld_d    = s1_vld_q;
        s1_data_d   = s1_data_q;
        s1_last_d   = s1_last_q;

        // wr_addr is zero only for the first word of a block in either order
        if (accept && (wr_addr == '0)) begin
            bank_mode_d[wr_bank_q] = mode;
        end
        if (accept && wr_last) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = !wr_bank_q;
        end
        // The last read is already in flight, so the bank is free for refill
        if (issue && rd_last) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = !rd_bank_q;
        end

        if (err_set) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end

        if (pop) begin
            s0_vld_d  = s1_vld_q;
            s0_data_d = s1_data_q;
            s0_last_d = s1_last_q;
            s1_vld_d  = 1'b0;
        end
        if (rd_vld_q) begin
            if (!s0_vld_d) begin
                s0_vld_d  = 1'b1;
                s0_data_d = rd_data_q;
                s0_last_d = rd_last_q;
            end else begin
                s1_vld_d  = 1'b1;
                s1_data_d = rd_data_q;
                s1_last_d = rd_last_q;
            end
        end
    end

    // Control and skid-buffer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q       <= 1'b0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            full_q      <= '0;
            bank_mode_q <= '0;
            err_q       <= 1'b0;
            rd_vld_q    <= 1'b0;
            rd_last_q   <= 1'b0;
            s0_vld_q    <= 1'b0;
            s0_data_q   <= '0;
            s0_last_q   <= 1'b0;
            s1_vld_q    <= 1'b0;
            s1_data_q   <= '0;
            s1_last_q   <= 1'b0;
        end else begin
            run_q       <= run_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            full_q      <= full_d;
            bank_mode_q <= bank_mode_d;
            err_q       <= err_d;
            rd_vld_q    <= rd_vld_d;
            rd_last_q   <= rd_last_d;
            s0_vld_q    <= s0_vld_d;
            s0_data_q   <= s0_data_d;
            s0_last_q   <= s0_last_d;
            s1_vld_q    <= s1_vld_d;
            s1_data_q   <= s1_data_d;
            s1_last_q   <= s1_last_d;
        end
    end

`ifdef PRE_INTERLEAVER_ERR_CNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;

    assign err_cnt = err_cnt_q;

    // Saturating mismatch counter; a mismatch coincident with err_clr restarts at 1
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = err_set ? 16'd1 : 16'd0;
        end else if (err_set && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_pre_interleaver_v2.sv
// tb/tb_pre_interleaver_v2.sv - self-checking bench for pre_interleaver_v2
module tb_pre_interleaver_v2;

    localparam int L  = 65;
    localparam int N  = 4;
    localparam int BS = L * N;

    logic        clk = 1'b0;
    logic        rst_n, mode, s_axis_tvalid, s_axis_tlast, m_axis_tready, err_clr;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tready, m_axis_tvalid, m_axis_tlast, err_tlast;
    logic [31:0] m_axis_tdata;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    pre_interleaver_v2 dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mode         (mode),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tlast (s_axis_tlast),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast (m_axis_tlast),
        .err_tlast    (err_tlast),
        .err_clr      (err_clr)
    );

    typedef struct {
        int          blk;
        int          pos;
        logic [31:0] data;
        logic        last;
    } vec_t;

    logic [31:0] in_data[$];
    logic        in_mode[$];
    logic        in_last[$];
    logic [31:0] exp_data[$];
    logic        exp_last[$];
    logic [31:0] got_data[$];
    logic        got_last[$];
    logic [31:0] blk_x[BS];
    logic [31:0] stream_got[3*BS];
    vec_t        tbl[16];

    int total = 0;
    int bad   = 0;
    int acc_cnt, stall_cnt, blk0_hs_cyc, first_valid_cyc, last_out_cyc, stab_bad;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, want);
        end
    endtask

    task automatic fill_idx(input logic [31:0] base);
        for (int k = 0; k < BS; k++) blk_x[k] = base + 32'(k);
    endtask

    task automatic fill_rand();
        for (int k = 0; k < BS; k++) blk_x[k] = $urandom();
    endtask

    // Queue blk_x as one input block and append the reference output order
    task automatic add_block(input logic m, input int tl_pos);
        int idx;
        for (int k = 0; k < BS; k++) begin
            in_data.push_back(blk_x[k]);
            in_mode.push_back(m);
            in_last.push_back(k == tl_pos);
        end
        for (int i = 0; i < BS; i++) begin
            if (m == 1'b0) idx = (i % N) * L + i / N;   // read codeword-major columns
            else           idx = (i % L) * N + i / L;   // inverse permutation
            exp_data.push_back(blk_x[idx]);
            exp_last.push_back(i == BS - 1);
        end
    endtask

    task automatic drive(input int vprob, input int budget, input int max_words);
        int  n    = 0;
        int  sent = 0;
        logic hs;
        while (in_data.size() > 0 && n < budget && sent < max_words) begin
            @(posedge clk); #1;
            s_axis_tvalid = ($urandom_range(99) < vprob);
            s_axis_tdata  = in_data[0];
            s_axis_tlast  = in_last[0];
            mode          = in_mode[0];
            @(negedge clk);
            hs = s_axis_tvalid && s_axis_tready;
            if (s_axis_tvalid && !s_axis_tready) stall_cnt++;
            if (hs) begin
                void'(in_data.pop_front());
                void'(in_mode.pop_front());
                void'(in_last.pop_front());
                acc_cnt++;
                sent++;
                if (acc_cnt == BS) blk0_hs_cyc = cyc;
            end
            n++;
        end
        @(posedge clk); #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic collect(input int n, input int rprob, input int budget);
        int c = 0;
        logic pv = 1'b0, pr = 1'b0, pl = 1'b0;
        logic [31:0] pd = '0;
        while (got_data.size() < n && c < budget) begin
            @(posedge clk); #1;
            m_axis_tready = ($urandom_range(99) < rprob);
            @(negedge clk);
            if (pv && !pr && (!m_axis_tvalid || m_axis_tdata !== pd || m_axis_tlast !== pl)) stab_bad++;
            if (m_axis_tvalid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (m_axis_tvalid && m_axis_tready) begin
                got_data.push_back(m_axis_tdata);
                got_last.push_back(m_axis_tlast);
                last_out_cyc = cyc;
            end
            pv = m_axis_tvalid; pr = m_axis_tready; pd = m_axis_tdata; pl = m_axis_tlast;
            c++;
        end
        @(posedge clk); #1;
        m_axis_tready = 1'b0;
    endtask

    task automatic compare_all(input string tag);
        check({tag, "_count"}, 32'(got_data.size()), 32'(exp_data.size()));
        for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
            check({tag, "_data"}, got_data[i], exp_data[i]);
            check({tag, "_last"}, 32'(got_last[i]), 32'(exp_last[i]));
        end
        check({tag, "_stable"}, 32'(stab_bad), 32'd0);
        check({tag, "_inputs_left"}, 32'(in_data.size()), 32'd0);
        got_data.delete(); got_last.delete();
        exp_data.delete(); exp_last.delete();
        stab_bad = 0;
    endtask

    initial begin
        tbl[0]  = '{0, 0, 32'd0, 1'b0};     tbl[1]  = '{0, 1, 32'd65, 1'b0};
        tbl[2]  = '{0, 2, 32'd130, 1'b0};   tbl[3]  = '{0, 3, 32'd195, 1'b0};
        tbl[4]  = '{0, 4, 32'd1, 1'b0};     tbl[5]  = '{0, 5, 32'd66, 1'b0};
        tbl[6]  = '{0, 258, 32'd194, 1'b0}; tbl[7]  = '{0, 259, 32'd259, 1'b1};
        tbl[8]  = '{1, 0, 32'd0, 1'b0};     tbl[9]  = '{1, 1, 32'd4, 1'b0};
        tbl[10] = '{1, 2, 32'd8, 1'b0};     tbl[11] = '{1, 64, 32'd256, 1'b0};
        tbl[12] = '{1, 65, 32'd1, 1'b0};    tbl[13] = '{1, 259, 32'd259, 1'b1};
        tbl[14] = '{2, 1, 32'd1065, 1'b0};  tbl[15] = '{2, 259, 32'd1259, 1'b1};

        rst_n = 1'b0; mode = 1'b0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        s_axis_tdata = '0; m_axis_tready = 1'b0; err_clr = 1'b0;
        stab_bad = 0; stall_cnt = 0; acc_cnt = 0; first_valid_cyc = -1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rst_m_tlast", 32'(m_axis_tlast), 32'd0);
        check("rst_m_tdata", m_axis_tdata, 32'd0);
        check("rst_err_tlast", 32'(err_tlast), 32'd0);
        check("rst_s_tready", 32'(s_axis_tready), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("post_rst_s_tready", 32'(s_axis_tready), 32'd1);

        // Three back-to-back blocks, full rate, alternating modes
        fill_idx(0);    add_block(1'b0, BS - 1);
        fill_idx(0);    add_block(1'b1, BS - 1);
        fill_idx(1000); add_block(1'b0, BS - 1);
        acc_cnt = 0; stall_cnt = 0; first_valid_cyc = -1;
        fork
            drive(100, 2000, 100000);
            collect(3 * BS, 100, 3000);
        join
        // last word accepted on edge blk0_hs_cyc+1; valid must appear after two more edges
        check("latency", 32'(first_valid_cyc - blk0_hs_cyc), 32'd3);
        check("throughput_span", 32'(last_out_cyc - first_valid_cyc), 32'(3 * BS - 1));
        check("no_input_stall", 32'(stall_cnt), 32'd0);
        for (int i = 0; i < got_data.size() && i < 3 * BS; i++) stream_got[i] = got_data[i];
        for (int t = 0; t < 16; t++) begin
            if (tbl[t].blk * BS + tbl[t].pos < got_data.size()) begin
                check($sformatf("tbl%0d_data", t), got_data[tbl[t].blk * BS + tbl[t].pos], tbl[t].data);
                check($sformatf("tbl%0d_last", t), 32'(got_last[tbl[t].blk * BS + tbl[t].pos]), 32'(tbl[t].last));
            end else begin
                check($sformatf("tbl%0d_missing", t), 32'(got_data.size()), 32'(3 * BS));
            end
        end
        compare_all("stream");

        // Round trip of interleaved block through deinterleave, then random blocks and stalls
        for (int k = 0; k < BS; k++) blk_x[k] = stream_got[k];
        add_block(1'b1, BS - 1);
        for (int b = 0; b < 3; b++) begin
            fill_rand();
            add_block(1'($urandom_range(1)), BS - 1);
        end
        fork
            drive(50, 20000, 100000);
            collect(4 * BS, 30, 20000);
        join
        for (int i = 0; i < BS && i < got_data.size(); i++) check("roundtrip", got_data[i], 32'(i));
        compare_all("random");

        // Both banks full: output stalled for 600 cycles
        fill_rand(); add_block(1'b0, BS - 1);
        fill_rand(); add_block(1'b1, BS - 1);
        fill_rand(); add_block(1'b0, BS - 1);
        acc_cnt = 0;
        drive(100, 600, 100000);
        check("full_accept_cnt", 32'(acc_cnt), 32'(2 * BS));
        check("full_tready_low", 32'(s_axis_tready), 32'd0);
        check("full_out_valid", 32'(m_axis_tvalid), 32'd1);
        fork
            drive(100, 5000, 100000);
            collect(3 * BS, 100, 5000);
        join
        compare_all("full");

        // Early tlast on word 100
        fill_rand(); add_block(1'b0, 100);
        fork
            begin
                drive(100, 1000, 100);
                @(posedge clk); #1;
                s_axis_tvalid = 1'b1; s_axis_tdata = in_data[0];
                s_axis_tlast = in_last[0]; mode = in_mode[0];
                @(negedge clk);
                check("err_before_early", 32'(err_tlast), 32'd0);
                check("tready_at_early", 32'(s_axis_tready), 32'd1);
                void'(in_data.pop_front()); void'(in_mode.pop_front()); void'(in_last.pop_front());
                @(posedge clk); #1;
                s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
                check("err_after_early", 32'(err_tlast), 32'd1);
                drive(100, 1000, 100000);
            end
            collect(BS, 100, 2000);
        join
        compare_all("early_tlast");
        check("err_sticky", 32'(err_tlast), 32'd1);
        @(posedge clk); #1; err_clr = 1'b1;
        @(posedge clk); #1; err_clr = 1'b0;
        check("err_cleared", 32'(err_tlast), 32'd0);

        // Missing tlast on the final word with err_clr in the same cycle: set wins
        fill_rand(); add_block(1'b1, -1);
        fork
            begin
                drive(100, 1000, BS - 1);
                @(posedge clk); #1;
                s_axis_tvalid = 1'b1; s_axis_tdata = in_data[0];
                s_axis_tlast = in_last[0]; mode = in_mode[0]; err_clr = 1'b1;
                @(negedge clk);
                check("err_before_missing", 32'(err_tlast), 32'd0);
                check("tready_at_missing", 32'(s_axis_tready), 32'd1);
                void'(in_data.pop_front()); void'(in_mode.pop_front()); void'(in_last.pop_front());
                @(posedge clk); #1;
                s_axis_tvalid = 1'b0; err_clr = 1'b0;
                check("err_set_wins", 32'(err_tlast), 32'd1);
            end
            collect(BS, 100, 2000);
        join
        compare_all("missing_tlast");
        @(posedge clk); #1; err_clr = 1'b1;
        @(posedge clk); #1; err_clr = 1'b0;

        // Reset in the middle of a block while output is pending
        fill_rand(); add_block(1'b0, BS - 1);
        drive(100, 1000, 100000);
        repeat (4) @(posedge clk);
        #1;
        check("valid_before_reset", 32'(m_axis_tvalid), 32'd1);
        fill_rand(); add_block(1'b1, BS - 1);
        drive(100, 1000, 130);
        rst_n = 1'b0;
        #1;
        check("midrst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("midrst_m_tdata", m_axis_tdata, 32'd0);
        check("midrst_m_tlast", 32'(m_axis_tlast), 32'd0);
        check("midrst_err", 32'(err_tlast), 32'd0);
        in_data.delete(); in_mode.delete(); in_last.delete();
        exp_data.delete(); exp_last.delete();
        got_data.delete(); got_last.delete();
        stab_bad = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        fill_idx(0); add_block(1'b0, BS - 1);
        fork
            drive(100, 2000, 100000);
            collect(BS, 100, 2000);
        join
        compare_all("after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pre_interleaver_v2.md
Name: pre_interleaver_v2

Overview:
Parametrised ping-pong block interleaver/deinterleaver for the encoder/decoder data path. It is the successor to the fixed 32-bit column-write/row-read pre-interleaver. Adds generic width, runtime direction select per block, AXIS tlast framing with error detection, and registered RAM reads so the storage infers block RAM. One block is NUM_CODEWORDS x CODEWORD_LEN words, and the two banks alternate between fill and drain.

Parameters:
DATA_WIDTH, 32, word width of both AXIS data buses
CODEWORD_LEN, 65, words per codeword (L)
NUM_CODEWORDS, 4, codewords per block (N)
BLOCK_SIZE, CODEWORD_LEN*NUM_CODEWORDS, derived localparam, never overridden

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
mode  in  1  0 = interleave, 1 = deinterleave; sampled on the first accepted word of each block
s_axis_tdata  in  DATA_WIDTH  input word
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready
s_axis_tlast  in  1  input end-of-block marker
m_axis_tdata  out  DATA_WIDTH  output word
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  output ready
m_axis_tlast  out  1  high on the last word of each output block
err_tlast  out  1  sticky tlast-mismatch flag
err_clr  in  1  synchronous clear for err_tlast

Behaviour:
- Reset (async, rst_n=0):
  - all outputs 0; both banks empty; write and read pointers on bank 0; counters 0.
  - A reset mid-block discards all stored data.
- Storage: two banks, each a flat BLOCK_SIZE x DATA_WIDTH RAM. Synchronous read, 1-cycle latency.
- Write side:
  - s_axis_tready = !full[wr_bank]; registered flags only, no combinational path from m_axis_tready.
  - Each accepted word advances the write index k (0..BLOCK_SIZE-1).
  - On k = BLOCK_SIZE-1: set full[wr_bank], toggle wr_bank, wrap k to 0.
- Address mapping. Use incremental row/column counters; no divide or modulo hardware.
  - mode 0, write: addr = k.
  - mode 0, read index j: addr = (j mod N)*L + j/N.
  - mode 1: the inverse. Write j goes to (j mod N)*L + j/N; read is linear.
  - Mode is latched per bank at write k=0 and used by that bank's drain.
- Read side:
  - Address/issue stage feeds a 2-entry output skid buffer, giving 1 word/cycle throughput under continuous m_axis_tready.
  - m_axis_tvalid rises exactly 2 cycles after the accepting edge of the last input word, provided the read side was idle.
  - m_axis_tdata, m_axis_tvalid and m_axis_tlast hold stable while valid && !ready.
  - full[rd_bank] clears on the cycle the final read address is issued, not on output handshake; the bank may then be refilled, because its data is already in the skid buffer.
  - Then toggle rd_bank.
- Simultaneous events:
  - A set on one bank and a clear on the other in the same cycle are both honoured.
  - The same bank cannot be set and cleared in one cycle.
- tlast handling:
  - Framing is by count only.
  - err_tlast sets on an accepted word where s_axis_tlast != (k == BLOCK_SIZE-1).
  - err_clr clears it, but a set in the same cycle wins.
- Both banks full: s_axis_tready=0 until the read side frees one.

Optional Feature:
- Macro PRE_INTERLEAVER_ERR_CNT_EN.
- Defined:
  - adds output err_cnt [15:0]: count of tlast-mismatch events, saturating at 16'hFFFF.
  - cleared by reset and by err_clr; an increment coincident with err_clr yields 1.
- Undefined: no port, no counter; err_tlast behaviour is unchanged.

Decomposition:
- Package pre_interleaver_pkg holds:
  - MODE_INTERLEAVE / MODE_DEINTERLEAVE constants.
  - a function computing counter widths ($clog2 with a minimum of 1).
- One sub-module: pre_interleaver_addr_gen. It is the row/column counter pair producing a flat address for linear or transposed order. It is instantiated once for write and once for read, with the mode and advance/clear inputs.
- RAM is inferred inline.

Test Plan:
- Interleave, L=65, N=4, mode=0, input 0..259 with tready=1 -> output 0,65,130,195,1,66,...,259; tlast only on 259; no input stall over 3 back-to-back blocks.
- Deinterleave round trip: feed the mode-0 output into a second instance in mode 1 -> 0..259 restored in order; mode switching between consecutive blocks is honoured per block.
- Random tvalid (50%) and m_axis_tready (30%) -> identical output sequence; data held stable under stall; throughput is 1 word/cycle once ready is held high.
- Both banks full (tready=0 for 600 cycles) -> s_axis_tready=0 after 520 accepted words; no data loss after release.
- tlast asserted early on word 100 -> err_tlast=1 from the next cycle; block framing unchanged; err_clr pulse -> 0; with ERR_CNT_EN, err_cnt=1.
- rst_n pulse mid-block (word 130) -> all outputs 0 immediately; next block 0..259 processed correctly from bank 0.
